// File: rtl/upuart_rx_path.sv
// UART receive path: programmable baud-tick generator plus a 16x-oversampling 8N1 receiver.
// The receiver re-phases the generator on every accepted start-bit edge.
module upuart_rx_path (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] count_val,
   input  logic        ovrsamp,
   input  logic        enable,
   input  logic        rxd,
   output logic [7:0]  data_out,
   output logic        data_wr,
   output logic        baud_tick
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

   state_t      state, state_next;
   logic        rxd_meta, rxs, rxs_prev;
   logic [31:0] cnt, terminal;
   logic        brreset;
   logic [3:0]  tick_cnt, tick_cnt_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shift, shift_next;
   logic [7:0]  data_out_next;
   logic        data_wr_next;

   // rxs_prev trails rxs by one clock so a 1->0 transition is seen as a single-cycle event.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rxd_meta <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxs      <= rxd_meta;
         rxs_prev <= rxs;
      end
   end

   assign terminal = ovrsamp ? (count_val - 32'd1) : ({count_val[27:0], 4'b0000} - 32'd1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt       <= 32'd0;
         baud_tick <= 1'b0;
      end else if (brreset || !enable) begin
         cnt       <= 32'd0;
         baud_tick <= 1'b0;
      end else if (cnt == terminal) begin
         cnt       <= 32'd0;
         baud_tick <= 1'b1;
      end else begin
         cnt       <= cnt + 32'd1;
         baud_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         tick_cnt <= 4'd0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         data_out <= 8'h00;
         data_wr  <= 1'b0;
      end else begin
         state    <= state_next;
         tick_cnt <= tick_cnt_next;
         bit_idx  <= bit_idx_next;
         shift    <= shift_next;
         data_out <= data_out_next;
         data_wr  <= data_wr_next;
      end
   end

   // Start check lands on tick 8 (mid-bit); every later sample is 16 ticks apart.
   always_comb begin
      state_next    = state;
      tick_cnt_next = tick_cnt;
      bit_idx_next  = bit_idx;
      shift_next    = shift;
      data_out_next = data_out;
      data_wr_next  = 1'b0;
      brreset       = 1'b0;
      case (state)
         IDLE: begin
            if (rxs_prev && !rxs) begin
               brreset       = 1'b1;
               tick_cnt_next = 4'd0;
               state_next    = START;
            end
         end
         START: begin
            if (baud_tick) begin
               if (tick_cnt == 4'd7) begin
                  tick_cnt_next = 4'd0;
                  bit_idx_next  = 3'd0;
                  state_next    = rxs ? IDLE : DATA;
               end else begin
                  tick_cnt_next = tick_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (tick_cnt == 4'd15) begin
                  tick_cnt_next = 4'd0;
                  shift_next    = {rxs, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state_next = STOP;
                  end else begin
                     bit_idx_next = bit_idx + 3'd1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt + 4'd1;
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (tick_cnt == 4'd15) begin
                  tick_cnt_next = 4'd0;
                  if (rxs) begin
                     data_out_next = shift;
                     data_wr_next  = 1'b1;
                     state_next    = IDLE;
                  end else begin
                     state_next = WAITHI;
                  end
               end else begin
                  tick_cnt_next = tick_cnt + 4'd1;
               end
            end
         end
         WAITHI: begin
            if (rxs) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_upuart_rx_path.sv
// Directed bench for upuart_rx_path: generator periods, single and back-to-back bytes,
// false start, framing error and mid-frame reset.
module tb_upuart_rx_path;

   localparam int BIT_CLKS = 432;

   logic        clk;
   logic        nrst;
   logic [31:0] count_val;
   logic        ovrsamp;
   logic        enable;
   logic        rxd;
   logic [7:0]  data_out;
   logic        data_wr;
   logic        baud_tick;

   int          checks = 0;
   int          errors = 0;
   int          tick_count = 0;
   logic        wr_prev = 1'b0;
   logic [7:0]  wr_q[$];
   time         last_wr_time = 0;
   time         fall_time = 0;

   upuart_rx_path dut (
      .clk       (clk),
      .nrst      (nrst),
      .count_val (count_val),
      .ovrsamp   (ovrsamp),
      .enable    (enable),
      .rxd       (rxd),
      .data_out  (data_out),
      .data_wr   (data_wr),
      .baud_tick (baud_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: records every received byte and checks the strobe is a single cycle.
   always @(negedge clk) begin
      if (data_wr) begin
         wr_q.push_back(data_out);
         last_wr_time = $time;
         check("wr_single_cycle", {31'd0, wr_prev}, 32'd0);
      end
      wr_prev = data_wr;
      if (baud_tick) tick_count++;
   end

   task automatic measure_period(output int period);
      int n;
      n = 0;
      while (!baud_tick && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      period = 1;
      while (!baud_tick && period < 1000) begin
         @(negedge clk);
         period++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxd = 1'b0;
      fall_time = $time;
      repeat (BIT_CLKS - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rxd = b[i];
         repeat (BIT_CLKS - 1) @(negedge clk);
      end
      @(negedge clk);
      rxd = stop_bit;
      repeat (BIT_CLKS - 1) @(negedge clk);
   endtask

   function automatic logic [31:0] pop_byte();
      if (wr_q.size() > 0) return {24'd0, wr_q.pop_front()};
      return 32'hDEAD;
   endfunction

   initial begin
      int p;
      int t0;
      nrst      = 1'b0;
      rxd       = 1'b1;
      count_val = 32'd4;
      ovrsamp   = 1'b1;
      enable    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_data_out", {24'd0, data_out}, 32'h00);
      check("reset_data_wr", {31'd0, data_wr}, 32'd0);
      check("reset_baud_tick", {31'd0, baud_tick}, 32'd0);
      check("reset_state_idle", {29'd0, dut.state}, 32'd0);
      nrst = 1'b1;

      // Generator periods
      enable = 1'b1;
      measure_period(p);
      check("period_ovr1_a", p, 32'd4);
      measure_period(p);
      check("period_ovr1_b", p, 32'd4);
      ovrsamp = 1'b0;
      measure_period(p);
      measure_period(p);
      check("period_ovr0", p, 32'd64);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      t0 = tick_count;
      repeat (200) @(negedge clk);
      check("disabled_no_ticks", tick_count - t0, 32'd0);
      check("disabled_cnt_zero", dut.cnt, 32'd0);

      // Single byte at 27 clocks/tick, 432 clocks/bit
      count_val = 32'd27;
      ovrsamp   = 1'b1;
      enable    = 1'b1;
      repeat (50) @(negedge clk);
      wr_q.delete();
      send_byte(8'h41, 1'b1);
      repeat (20) @(negedge clk);
      check("single_count", wr_q.size(), 32'd1);
      check("single_byte", pop_byte(), 32'h41);
      check("single_data_out", {24'd0, data_out}, 32'h41);
      check("single_latency", 32'((last_wr_time - fall_time) / 10), 32'd4108);

      // Back-to-back, no idle gap
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      check("b2b_count", wr_q.size(), 32'd3);
      check("b2b_first", pop_byte(), 32'h55);
      check("b2b_second", pop_byte(), 32'hAA);
      check("b2b_third", pop_byte(), 32'hFF);

      // False start
      @(negedge clk);
      rxd = 1'b0;
      repeat (100) @(negedge clk);
      rxd = 1'b1;
      repeat (1000) @(negedge clk);
      check("false_start_no_wr", wr_q.size(), 32'd0);
      send_byte(8'h30, 1'b1);
      repeat (20) @(negedge clk);
      check("after_false_count", wr_q.size(), 32'd1);
      check("after_false_byte", pop_byte(), 32'h30);

      // Framing error: stop bit low, line held low
      send_byte(8'h12, 1'b0);
      repeat (2000) @(negedge clk);
      rxd = 1'b1;
      repeat (500) @(negedge clk);
      check("frame_err_no_wr", wr_q.size(), 32'd0);
      check("frame_err_data_held", {24'd0, data_out}, 32'h30);
      send_byte(8'h34, 1'b1);
      repeat (20) @(negedge clk);
      check("after_frame_err_count", wr_q.size(), 32'd1);
      check("after_frame_err_byte", pop_byte(), 32'h34);

      // Reset in the middle of the data bits of 0x7E
      @(negedge clk);
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      check("pre_reset_in_data", {29'd0, dut.state}, 32'd2);
      nrst = 1'b0;
      @(negedge clk);
      check("midreset_data_out", {24'd0, data_out}, 32'h00);
      check("midreset_data_wr", {31'd0, data_wr}, 32'd0);
      check("midreset_baud_tick", {31'd0, baud_tick}, 32'd0);
      check("midreset_state", {29'd0, dut.state}, 32'd0);
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      nrst = 1'b1;
      repeat (1000) @(negedge clk);
      check("midreset_no_wr", wr_q.size(), 32'd0);
      send_byte(8'h7E, 1'b1);
      repeat (20) @(negedge clk);
      check("after_reset_count", wr_q.size(), 32'd1);
      check("after_reset_byte", pop_byte(), 32'h7E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
